// File: rtl/seq_alu_pkg.sv
// Shared op-codes and FSM state encoding for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOTA = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_ADD  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, done after WIDTH steps.
module seq_alu_mul #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] prod
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        if (start) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign done = done_q;
    assign prod = acc_q;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready on both sides; the iterative multiply is built
// only when SEQ_ALU_MUL_EN is defined, otherwise op 1000 behaves as an illegal op.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       sel,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             Negative,
    output logic             Zero,
    output logic             Overflow
);

    // Handshake: an op is taken when in_valid & in_ready (IDLE only); the result is
    // handed off when out_valid & out_ready (DONE only), so both never coincide.
    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_y;
    logic             alu_cout, alu_ovf;
    logic             is_sub, take_mul;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH:0]   sum;

    assign is_sub = (sel == OP_SUB);
    assign add_b  = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub | Cin};

    always_comb begin
        alu_y    = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (sel)
            OP_AND:  alu_y = A & B;
            OP_OR:   alu_y = A | B;
            OP_NOTA: alu_y = ~A;
            OP_NOR:  alu_y = ~(A | B);
            OP_XOR:  alu_y = A ^ B;
            OP_NAND: alu_y = ~(A & B);
            OP_ADD, OP_SUB: begin
                alu_y    = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                // Same-sign operands producing a different-sign result is signed overflow.
                alu_ovf  = (A[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            default: alu_y = '0;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign take_mul  = (sel == OP_MUL);
    assign mul_start = in_valid & in_ready & take_mul;

    seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (A),
        .b     (B),
        .done  (mul_done),
        .prod  (mul_prod)
    );
`else
    assign take_mul = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (take_mul) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        y_d     = alu_y;
                        cout_d  = alu_cout;
                        ovf_d   = alu_ovf;
                    end
                end
            end
            BUSY: begin
`ifdef SEQ_ALU_MUL_EN
                if (mul_done) begin
                    state_d = DONE;
                    y_d     = mul_prod[WIDTH-1:0];
                    cout_d  = 1'b0;
                    ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Y         = y_q;
    assign Cout      = cout_q;
    assign Overflow  = ovf_q;
    assign Negative  = y_q[WIDTH-1];
    assign Zero      = (y_q == '0);

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=32); MUL expectations follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

    localparam int W = 32;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   sel;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         Cout;
    logic         Negative;
    logic         Zero;
    logic         Overflow;

    logic [W+3:0] exp_q[$];
    int           checks = 0;
    int           failures = 0;

    wire [W+3:0] obs = {Y, Cout, Negative, Zero, Overflow};
    localparam logic [W+3:0] RESET_OBS = {{W{1'b0}}, 4'b0010};

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .sel       (sel),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .Cout      (Cout),
        .Negative  (Negative),
        .Zero      (Zero),
        .Overflow  (Overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] s, input logic c);
        logic [W-1:0]   y;
        logic           co, ov;
        logic [W:0]     wide;
        logic [2*W-1:0] p;
        longint         sa, smax, smin;
        y    = '0;
        co   = 1'b0;
        ov   = 1'b0;
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        case (s)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: y = ~a;
            4'd3: y = ~(a | b);
            4'd4: y = a ^ b;
            4'd5: y = ~(a & b);
            4'd6: begin
                wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
                y    = wide[W-1:0];
                co   = wide[W];
                sa   = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
                ov   = (sa > smax) || (sa < smin);
            end
            4'd7: begin
                y  = a - b;
                co = (a >= b);
                sa = longint'($signed(a)) - longint'($signed(b));
                ov = (sa > smax) || (sa < smin);
            end
            4'd8: begin
                if (MUL_ON) begin
                    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    y  = p[W-1:0];
                    ov = |p[2*W-1:W];
                end
            end
            default: y = '0;
        endcase
        return {y, co, y[W-1], (y == '0), ov};
    endfunction

    // Issues one op, keeps in_valid high with garbage until handoff, checks latency,
    // result against the scoreboard, stability under backpressure and the handoff.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic c, input int hold);
        int           lat;
        int           exp_lat;
        logic [W+3:0] exp;
        logic [W+3:0] held;
        exp_lat = (MUL_ON && s == 4'd8) ? W + 1 : 1;
        lat = 0;
        while (!in_ready && lat < 100) begin
            tick();
            lat++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout in_ready=%b required=1", in_ready);
            return;
        end
        exp_q.push_back(model(a, b, s, c));
        A = a; B = b; sel = s; Cin = c;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        A   = $urandom;
        B   = $urandom;
        sel = 4'($urandom_range(0, 15));
        Cin = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== exp_lat) begin
            failures++;
            $display("FAIL latency op=%h got=%0d required=%0d", s, lat, exp_lat);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_in_done got=%b required=0", in_ready);
        end
        exp = exp_q.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL result op=%h a=%h b=%h cin=%b got=%h required=%h", s, a, b, c, obs, exp);
        end
        held = obs;
        for (int i = 0; i < hold; i++) begin
            tick();
            checks++;
            if (obs !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold cycle=%0d got=%h/%b/%b required=%h/1/0",
                         i, obs, out_valid, in_ready, held);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handoff got out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; sel = '0; Cin = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || obs !== RESET_OBS) begin
            failures++;
            $display("FAIL reset_outputs got=%b/%h required=0/%h", out_valid, obs, RESET_OBS);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        run_op(32'h7FFFFFFF, 32'h1, 4'd6, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'h0, 4'd6, 1'b1, 0);
        run_op(32'h80000000, 32'h80000000, 4'd6, 1'b0, 0);
        for (int i = 0; i < 3; i++) run_op($urandom, $urandom, 4'd6, 1'($urandom_range(0, 1)), 0);
    endtask

    task automatic test_sub();
        run_op(32'd5, 32'd5, 4'd7, 1'b0, 0);
        run_op(32'd0, 32'd1, 4'd7, 1'b1, 0);
        run_op(32'h80000000, 32'd1, 4'd7, 1'b0, 0);
        for (int i = 0; i < 3; i++) run_op($urandom, $urandom, 4'd7, 1'b0, 0);
    endtask

    task automatic test_logic();
        for (int s = 0; s < 6; s++) run_op(32'hF0F0F0F0, 32'hFF00FF00, 4'(s), 1'b0, 0);
        for (int s = 9; s < 16; s++) run_op($urandom, $urandom, 4'(s), 1'b1, 0);
    endtask

    task automatic test_backpressure();
        run_op(32'h12345678, 32'h9ABCDEF0, 4'd6, 1'b1, 5);
        run_op(32'hF0F0F0F0, 32'h0F0F0F0F, 4'd3, 1'b0, 5);
    endtask

    task automatic test_mul();
        run_op(32'h00010000, 32'h00010000, 4'd8, 1'b0, 2);
        run_op(32'd3, 32'd5, 4'd8, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd8, 1'b0, 0);
        run_op($urandom, 32'($urandom_range(0, 65535)), 4'd8, 1'b0, 1);
    endtask

    task automatic test_reset_mid_op();
        run_op(32'h0000FFFF, 32'h00000001, 4'd6, 1'b0, 0);
        A = 32'd7; B = 32'd9; sel = 4'd8; Cin = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || obs !== RESET_OBS) begin
            failures++;
            $display("FAIL reset_mid_op got=%b/%h required=0/%h", out_valid, obs, RESET_OBS);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_release got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        run_op(32'd6, 32'd7, 4'd8, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            run_op($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_backpressure();
        test_mul();
        test_reset_mid_op();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
